// File: rtl/counter_arb_ctrl.sv
// counter_arb_ctrl: round-robin arbiter that lends one WIDTH-bit tick counter to two requesters.
// The winner gets a run of (len+1) ticks and a one-cycle done pulse when it completes.
module counter_arb_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             tick,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       done,
    output logic [3:0]       io_oeb
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_lenQ;
    logic             r_rrLast;

    state_t           w_state;
    logic [1:0]       w_gnt;
    logic [1:0]       w_done;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_lenQ;
    logic             w_rrLast;
    logic             w_winner;
    logic             w_ownerReq;

    // The last winner is also the current owner while a run is active.
    assign w_winner   = req[1] & (~req[0] | ~r_rrLast);
    assign w_ownerReq = req[r_rrLast];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_count  <= '0;
            r_lenQ   <= '0;
            r_rrLast <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_gnt    <= w_gnt;
            r_done   <= w_done;
            r_count  <= w_count;
            r_lenQ   <= w_lenQ;
            r_rrLast <= w_rrLast;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_done   = 2'b00;
        w_count  = r_count;
        w_lenQ   = r_lenQ;
        w_rrLast = r_rrLast;
        case (r_state)
            ST_IDLE: begin
                w_gnt   = 2'b00;
                w_count = '0;
                if (|req) begin
                    w_state  = ST_RUN;
                    w_gnt    = {w_winner, ~w_winner};
                    w_lenQ   = w_winner ? len1 : len0;
                    w_rrLast = w_winner;
                end
            end
            ST_RUN: begin
                // Withdrawal wins over reaching the terminal count.
                if (!w_ownerReq) begin
                    w_state = ST_IDLE;
                    w_gnt   = 2'b00;
                    w_count = '0;
                end else if (tick && (r_count == r_lenQ)) begin
                    w_state = ST_DONE;
                    w_done  = r_gnt;
                end else if (tick) begin
                    w_count = r_count + ONE;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
                w_gnt   = 2'b00;
                w_count = '0;
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = 2'b00;
                w_count = '0;
            end
        endcase
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign count  = r_count;
    assign busy   = (r_state != ST_IDLE);
    assign io_oeb = 4'b0000;

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Scoreboard bench for counter_arb_ctrl: a run-level reference model predicts every cycle's
// outputs into a queue, and an independent monitor pops and compares after each clock edge.
module tb_counter_arb_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic       tick;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] count;
    logic [1:0] done;
    logic [3:0] io_oeb;

    counter_arb_ctrl #(.WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .len0   (len0),
        .len1   (len1),
        .tick   (tick),
        .gnt    (gnt),
        .busy   (busy),
        .count  (count),
        .done   (done),
        .io_oeb (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {gnt[1:0], done[1:0], count[3:0], busy, io_oeb[3:0]}
    logic [12:0] expQ[$];
    int          testsRun  = 0;
    int          testsFail = 0;
    int          cycleNo   = 0;
    bit          started   = 1'b0;

    // Run-level model: who owns the counter, how long its run is, how many ticks it has used.
    int mOwner = -1;
    int mLen   = 0;
    int mUsed  = 0;
    int mLast  = 1;

    function automatic void modelEdge(input bit r, input bit [1:0] rq,
                                      input bit [3:0] l0, input bit [3:0] l1, input bit tk);
        int w;
        if (r) begin
            mOwner = -1;
            mUsed  = 0;
            mLen   = 0;
            mLast  = 1;
        end else if (mOwner < 0) begin
            if (rq != 2'b00) begin
                w      = (rq == 2'b11) ? (1 - mLast) : (rq[1] ? 1 : 0);
                mOwner = w;
                mLast  = w;
                mLen   = w ? int'(l1) : int'(l0);
                mUsed  = 0;
            end
        end else if (mUsed > mLen) begin
            mOwner = -1;
        end else if (!rq[mOwner]) begin
            mOwner = -1;
        end else if (tk) begin
            mUsed++;
        end
    endfunction

    function automatic logic [12:0] modelOutputs();
        logic [1:0] g;
        logic [1:0] d;
        logic [3:0] c;
        logic       b;
        g = 2'b00;
        d = 2'b00;
        c = 4'd0;
        b = 1'b0;
        if (mOwner >= 0) begin
            g = (mOwner == 1) ? 2'b10 : 2'b01;
            b = 1'b1;
            if (mUsed > mLen) begin
                d = g;
                c = 4'(mLen);
            end else begin
                c = 4'(mUsed);
            end
        end
        return {g, d, c, b, 4'b0000};
    endfunction

    function automatic bit modelInDone();
        return (mOwner >= 0) && (mUsed > mLen);
    endfunction

    function automatic int modelCount();
        return (mOwner >= 0) ? mUsed : -1;
    endfunction

    // Drive one cycle of inputs away from the active edge and queue the predicted response.
    task automatic applyStimulus(input bit r, input bit [1:0] rq,
                                 input bit [3:0] l0, input bit [3:0] l1, input bit tk);
        @(negedge clk);
        reset = r;
        req   = rq;
        len0  = l0;
        len1  = l1;
        tick  = tk;
        modelEdge(r, rq, l0, l1, tk);
        expQ.push_back(modelOutputs());
        started = 1'b1;
    endtask

    task automatic checkOutput();
        logic [12:0] expV;
        logic [12:0] actV;
        if (expQ.size() == 0) return;
        expV = expQ.pop_front();
        actV = {gnt, done, count, busy, io_oeb};
        testsRun++;
        if (actV !== expV) begin
            testsFail++;
            $display("[TB] FAIL cycle%0d outputs: got gnt=%b done=%b count=%0d busy=%b oeb=%b, expected gnt=%b done=%b count=%0d busy=%b oeb=%b",
                     cycleNo, actV[12:11], actV[10:9], actV[8:5], actV[4], actV[3:0],
                     expV[12:11], expV[10:9], expV[8:5], expV[4], expV[3:0]);
        end
    endtask

    // Monitor: samples one time unit after every rising edge, independently of stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                cycleNo++;
                checkOutput();
            end
        end
    end

    // Hold a request until the model reports the done cycle, bounded by a cycle budget.
    task automatic runUntilDone(input bit [1:0] rq, input bit [3:0] l0, input bit [3:0] l1,
                                input bit alternateTick, input int budget);
        bit tk;
        tk = 1'b1;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b0, rq, l0, l1, tk);
            if (modelInDone()) break;
            if (alternateTick) tk = ~tk;
        end
        applyStimulus(1'b0, 2'b00, l0, l1, 1'b1);
        applyStimulus(1'b0, 2'b00, l0, l1, 1'b1);
    endtask

    initial begin
        bit [1:0] rq;
        reset = 1'b1;
        req   = 2'b00;
        len0  = 4'd0;
        len1  = 4'd0;
        tick  = 1'b0;

        applyStimulus(1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);

        $display("[TB] single run, len0=3");
        runUntilDone(2'b01, 4'd3, 4'd9, 1'b0, 20);

        $display("[TB] tick gating, len1=2");
        runUntilDone(2'b10, 4'd6, 4'd2, 1'b1, 30);

        $display("[TB] round robin, both requesting");
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 2'b11, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);

        $display("[TB] withdraw at count 2");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 2'b01, 4'd5, 4'd0, 1'b1);
            if (modelCount() == 2) break;
        end
        applyStimulus(1'b0, 2'b00, 4'd5, 4'd0, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd5, 4'd0, 1'b1);

        $display("[TB] withdraw on terminal count");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 2'b01, 4'd5, 4'd0, 1'b1);
            if (modelCount() == 5) break;
        end
        applyStimulus(1'b0, 2'b00, 4'd5, 4'd0, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd5, 4'd0, 1'b1);

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 2'b10, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 2'b10, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 2'b01, 4'd7, 4'd0, 1'b1);
            if (modelCount() == 4) break;
        end
        applyStimulus(1'b1, 2'b01, 4'd7, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 2'b11, 4'd1, 4'd1, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);

        $display("[TB] maximum length, len0=15");
        runUntilDone(2'b01, 4'hF, 4'd0, 1'b0, 40);

        $display("[TB] randomized traffic");
        rq = 2'b00;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) rq = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 99) == 0, rq,
                          4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
                          $urandom_range(0, 3) != 0);
        end

        repeat (3) @(posedge clk);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFail++;
            $display("[TB] FAIL scoreboard drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/counter_arb_ctrl.md
# counter_arb_ctrl

Controller that shares one WIDTH-bit tick counter between two requesters on the user project. Each requester asks for a timed run of (len+1) counter ticks. The block arbitrates round-robin, loads and sequences the counter, and returns a one-cycle done pulse to the winning requester. It sits between the user logic/GPIO requesters and the counter datapath, and owns that counter's register.

## Interface

Parameters:
- WIDTH, 4, counter and length width in bits.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset; sampled on posedge clk.
- req  input  2  per-requester run request; level, held until done or withdrawn.
- len0  input  WIDTH  run length for requester 0; sampled only at grant.
- len1  input  WIDTH  run length for requester 1; sampled only at grant.
- tick  input  1  count enable; counter advances only on cycles with tick=1.
- gnt  output  2  one-hot grant; all-zero when idle.
- busy  output  1  high whenever state is not IDLE.
- count  output  WIDTH  current counter value.
- done  output  2  one-cycle completion pulse to the owner.
- io_oeb  output  4  constant 4'b0000 (pads driven as outputs).

## Operation

- State machine: IDLE, RUN, DONE. All outputs are registered except busy (decoded from state) and io_oeb (tied).
- Reset (synchronous): state=IDLE, gnt=0, done=0, count=0, len_q=0, rr_last=1 (requester 0 wins first tie).
- IDLE, no req: hold; count=0.
- IDLE, any req bit set:
  - Winner: the sole requester; if both request, the one not equal to rr_last.
  - Next edge: state=RUN, gnt=onehot(winner), len_q=len of winner, count=0, rr_last=winner.
- RUN:
  - If req[owner]=0 (withdraw) → abort. Next edge: IDLE, gnt=0, count=0, no done pulse. Withdraw takes priority over terminal count.
  - Else if tick=1 and count==len_q → DONE; count holds len_q; done[owner]=1.
  - Else if tick=1 → count=count+1.
  - tick=0 → hold.
  - Requests from the non-owner are ignored; they are not queued.
- DONE: lasts exactly one cycle. done[owner]=1 and gnt still asserted. Next edge: IDLE, gnt=0, done=0, count=0.
- Arithmetic:
  - count never exceeds len_q, so no wrap occurs within a run.
  - len=0 yields one tick.
  - len=2^WIDTH-1 yields 2^WIDTH ticks; count reaches all-ones without overflow.
- len0/len1 changes after grant have no effect on the active run.
- Reset mid-run or in DONE: every output returns to its reset value at the next edge. A done pulse is never emitted for the interrupted run.

## Timing

- Grant latency: req seen in an IDLE cycle → gnt high on the following cycle.
- A run with tick held high and length L occupies L+1 RUN cycles plus 1 DONE cycle. gnt is high for L+2 cycles.
- Minimum spacing between back-to-back grants is one IDLE cycle, after DONE or after abort.
- done is high for exactly one cycle and coincides with the last gnt cycle.
- busy = 1 from the first gnt cycle through the DONE cycle inclusive.

## Test plan

- Single run: reset, then req=01, len0=3, tick=1 constant.
  - gnt=01 from cycle 1; count 0,1,2,3 on cycles 1–4.
  - done=01 on cycle 5 with count=3.
  - Cycle 6: gnt=0, count=0, busy=0.
- Tick gating: len1=2, req=10, tick alternating 1/0.
  - count advances only after tick=1 cycles.
  - done=10 after exactly 3 tick-high cycles in RUN; count=2 at done.
- Round-robin: req=11 held continuously, len0=len1=0, tick=1.
  - Grants alternate 01, 10, 01, 10, first grant 01.
  - Each grant followed by one IDLE cycle; done matches gnt.
- Withdraw: req=01, len0=5. Drop req0 when count=2.
  - Next cycle: gnt=0, count=0, no done.
  - Also drop req0 on the cycle count==len_q with tick=1 → abort, no done.
- Reset mid-run: len0=7, assert reset at count=4 for one cycle.
  - Next cycle: gnt=0, done=0, count=0, busy=0.
  - With req=11 afterwards, requester 0 wins.
- Boundaries and outputs:
  - len0=4'hF, tick=1: count reaches 15 without wrap; done after 16 RUN cycles.
  - io_oeb=0 throughout all tests.
